// File: rtl/nonrestoring_divider_32.sv
//==============================================================================
// Module      : nonrestoring_divider_32
// Description : Multi-cycle non-restoring integer divider for the ALU DIV/DIVU
//               path. One quotient bit is produced per clock on the operand
//               magnitudes, then a single fix-up cycle restores the final
//               remainder and applies the result signs. The result is packed
//               as z = {remainder, quotient}, the same HI/LO layout as the
//               multiplier product.
//
// Ports       : clock        rising-edge clock
//               reset        synchronous, active-high
//               start        begin an operation (accepted only when idle)
//               signed_op    1 = DIV (two's complement), 0 = DIVU
//               a            dividend, sampled on the accepting edge
//               b            divisor, sampled on the accepting edge
//               busy         operation in progress, start ignored
//               done         one-cycle pulse, z / div_by_zero valid
//               div_by_zero  set with done when b == 0, held until next done
//               z            {remainder -> HI, quotient -> LO}
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module nonrestoring_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] z
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int                 c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    state_t             r_state;
    logic [WIDTH:0]     r_p;          // signed partial remainder, one guard bit
    logic [WIDTH-1:0]   r_q;          // dividend magnitude shifting into quotient
    logic [WIDTH-1:0]   r_b_mag;      // divisor magnitude
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz_op;     // current operation is a divide by zero
    logic [2*WIDTH-1:0] r_z;
    logic               r_done;
    logic               r_div_by_zero;

    //--------------------------------------------------------------------------
    // Next-state wires
    //--------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [WIDTH:0]     w_p_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_b_mag_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_sign_q_nxt;
    logic               w_sign_r_nxt;
    logic               w_dbz_op_nxt;
    logic [2*WIDTH-1:0] w_z_nxt;
    logic               w_done_nxt;
    logic               w_div_by_zero_nxt;

    //--------------------------------------------------------------------------
    // Input magnitudes (only meaningful on the accepting edge)
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_mag_in;
    logic [WIDTH-1:0] w_b_mag_in;
    logic             w_b_zero;

    assign w_a_mag_in = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_b_mag_in = (signed_op && b[WIDTH-1]) ? -b : b;
    assign w_b_zero   = (b == '0);

    //--------------------------------------------------------------------------
    // One non-restoring step. The shifted remainder may exceed WIDTH+1 bits,
    // but the post-add/subtract value always lies in [-|b|, |b|), so modular
    // arithmetic on WIDTH+1 bits yields the exact result.
    //--------------------------------------------------------------------------
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_p_shift;
    logic [WIDTH:0]   w_p_step;
    logic [WIDTH-1:0] w_q_step;

    assign w_b_ext   = {1'b0, r_b_mag};
    assign w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_p_step  = r_p[WIDTH] ? (w_p_shift + w_b_ext) : (w_p_shift - w_b_ext);
    assign w_q_step  = {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};

    //--------------------------------------------------------------------------
    // Fix-up: restore a negative final remainder, then apply signs.
    //--------------------------------------------------------------------------
    logic [WIDTH:0]   w_p_fix;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_p_fix   = r_p[WIDTH] ? (r_p + w_b_ext) : r_p;
    assign w_rem_mag = w_p_fix[WIDTH-1:0];
    assign w_quo     = r_sign_q ? -r_q : r_q;
    assign w_rem     = r_sign_r ? -w_rem_mag : w_rem_mag;

    //--------------------------------------------------------------------------
    // Next-state / datapath logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_p_nxt           = r_p;
        w_q_nxt           = r_q;
        w_b_mag_nxt       = r_b_mag;
        w_cnt_nxt         = r_cnt;
        w_sign_q_nxt      = r_sign_q;
        w_sign_r_nxt      = r_sign_r;
        w_dbz_op_nxt      = r_dbz_op;
        w_z_nxt           = r_z;
        w_done_nxt        = 1'b0;
        w_div_by_zero_nxt = r_div_by_zero;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_b_mag_nxt  = w_b_mag_in;
                    w_sign_q_nxt = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    w_sign_r_nxt = signed_op & a[WIDTH-1];
                    w_p_nxt      = '0;
                    w_cnt_nxt    = '0;
                    w_dbz_op_nxt = w_b_zero;
                    if (w_b_zero) begin
                        // No iterations run; Q carries the raw dividend so
                        // the fix-up cycle can return it in the HI word.
                        w_q_nxt     = a;
                        w_state_nxt = S_FIXUP;
                    end else begin
                        w_q_nxt     = w_a_mag_in;
                        w_state_nxt = S_ITER;
                    end
                end
            end

            S_ITER: begin
                w_p_nxt   = w_p_step;
                w_q_nxt   = w_q_step;
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_FIXUP;
                end
            end

            S_FIXUP: begin
                if (r_dbz_op) begin
                    w_z_nxt           = {r_q, {WIDTH{1'b1}}};
                    w_div_by_zero_nxt = 1'b1;
                end else begin
                    w_z_nxt           = {w_rem, w_quo};
                    w_div_by_zero_nxt = 1'b0;
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_p           <= '0;
            r_q           <= '0;
            r_b_mag       <= '0;
            r_cnt         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dbz_op      <= 1'b0;
            r_z           <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_p           <= w_p_nxt;
            r_q           <= w_q_nxt;
            r_b_mag       <= w_b_mag_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sign_q      <= w_sign_q_nxt;
            r_sign_r      <= w_sign_r_nxt;
            r_dbz_op      <= w_dbz_op_nxt;
            r_z           <= w_z_nxt;
            r_done        <= w_done_nxt;
            r_div_by_zero <= w_div_by_zero_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. busy drops in the done cycle because the state is back in IDLE,
    // which is what lets a start in that cycle be accepted.
    //--------------------------------------------------------------------------
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign z           = r_z;

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_divider_32.sv
//==============================================================================
// Module      : tb_nonrestoring_divider_32
// Description : Self-checking bench for nonrestoring_divider_32. Directed
//               table vectors, handshake corner sequences and random vectors
//               compared with an arithmetic reference model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_nonrestoring_divider_32;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] z;

    int n_checks = 0;
    int n_fail   = 0;

    nonrestoring_divider_32 #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z           (z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] z;
        logic        dbz;
        int          lat;
        logic        hold;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division from plain arithmetic.
    function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                                    output logic [63:0] ez, output logic edbz);
        longint      sa, sb;
        logic [31:0] q, r;
        if (rb == 32'd0) begin
            ez   = {ra, 32'hFFFF_FFFF};
            edbz = 1'b1;
        end else if (rs) begin
            sa   = longint'($signed(ra));
            sb   = longint'($signed(rb));
            q    = 32'(sa / sb);
            r    = 32'(sa % sb);
            ez   = {r, q};
            edbz = 1'b0;
        end else begin
            q    = ra / rb;
            r    = ra % rb;
            ez   = {r, q};
            edbz = 1'b0;
        end
    endfunction

    // Starts an operation from the current (off-edge) time, waits for done.
    // intr > 0 pulses start with junk operands at that clock count.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic ts,
                          input logic [63:0] ez, input logic edbz, input int elat,
                          input int intr, input logic hold, input string name);
        int   n;
        logic seen;
        a = ta; b = tb_b; signed_op = ts; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_op = 1'($urandom);
        check({name, " busy"}, {63'd0, busy}, 64'd1);
        check({name, " done_low"}, {63'd0, done}, 64'd0);
        n = 1;
        seen = done;
        while (!seen && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (n == intr) begin
                start = 1'b1; a = $urandom; b = $urandom | 32'd1; signed_op = 1'b1;
            end else begin
                start = 1'b0;
            end
            seen = done;
        end
        check({name, " latency"}, 64'(n), 64'(elat));
        check({name, " z"}, z, ez);
        check({name, " dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        if (hold) begin
            @(posedge clock); #1;
            check({name, " pulse"}, {62'd0, done, busy}, 64'd0);
            @(posedge clock); #1;
            check({name, " hold"}, {z[63:1], div_by_zero}, {ez[63:1], edbz});
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] ez;
        logic        edbz;
        logic        saw_done;

        tbl[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,        32'd14},        1'b0, 34, 1'b1};
        tbl[1]  = '{32'hFFFF_FF9C, 32'd7,         1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, 34, 1'b0};
        tbl[2]  = '{32'd100,       32'hFFFF_FFF9, 1'b1, {32'd2,        32'hFFFF_FFF2}, 1'b0, 34, 1'b0};
        tbl[3]  = '{32'hFFFF_FFFF, 32'd2,         1'b0, {32'd1,        32'h7FFF_FFFF}, 1'b0, 34, 1'b0};
        tbl[4]  = '{32'hFFFF_FFFF, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'd0},         1'b0, 34, 1'b0};
        tbl[5]  = '{32'h1234_5678, 32'd0,         1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, 2,  1'b1};
        tbl[6]  = '{32'd7,         32'd7,         1'b0, {32'd0,        32'd1},         1'b0, 34, 1'b0};
        tbl[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0,        32'h8000_0000}, 1'b0, 34, 1'b1};
        tbl[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0,        32'd1},         1'b0, 34, 1'b0};
        tbl[9]  = '{32'd5,         32'd10,        1'b0, {32'd5,        32'd0},         1'b0, 34, 1'b0};
        tbl[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'd3},         1'b0, 34, 1'b0};
        tbl[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0},         1'b0, 34, 1'b0};
        tbl[12] = '{32'hFFFF_FFFF, 32'd0,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b1, 2,  1'b0};

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset state", {busy, done, div_by_zero, z[60:0]}, 64'd0);
        check("reset z", z, 64'd0);

        // Directed table; back-to-back vectors start in the done cycle.
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].z, tbl[i].dbz, tbl[i].lat,
                   0, tbl[i].hold, $sformatf("vec%0d", i));
        end

        // Start pulsed at clock 10 of a busy operation must be ignored.
        run_op(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b0, 34, 10, 1'b1, "ignore_start");

        // Leave a divide-by-zero result in z, then abort a new operation.
        run_op(32'hDEAD_BEEF, 32'd0, 1'b0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 1'b1, 2, 0, 1'b0, "dbz_pre");
        a = 32'd1000; b = 32'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort state", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("abort z", z, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", {63'd0, saw_done}, 64'd0);
        run_op(32'hFFFF_FF00, 32'd16, 1'b1, {32'd0, 32'hFFFF_FFF0}, 1'b0, 34, 0, 1'b1, "after_abort");

        // Random vectors against the reference model.
        for (int i = 0; i < 2000; i++) begin
            rs = 1'($urandom);
            case ($urandom_range(0, 15))
                0:       rb = 32'd0;
                1, 2, 3: rb = $urandom_range(1, 20);
                4, 5:    rb = -($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            if (rs && ra == 32'h8000_0000 && $urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
            ref_div(ra, rb, rs, ez, edbz);
            run_op(ra, rb, rs, ez, edbz, (rb == 32'd0) ? 2 : 34, 0, 1'b0,
                   $sformatf("rnd%0d a=%h b=%h s=%0d", i, ra, rb, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
